// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: default register addresses,
// control/status bit positions and the register-select encoding.
package timer_pkg;

    localparam logic [31:0] DEF_ADDR_TCNT = 32'hF000_0020;
    localparam logic [31:0] DEF_ADDR_TLIM = 32'hF000_0024;
    localparam logic [31:0] DEF_ADDR_TCTL = 32'hF000_0028;

    localparam int TCTL_READY   = 0;
    localparam int TCTL_OVERRUN = 2;
    localparam int TCTL_IE      = 4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_TCNT = 2'd1,
        SEL_TLIM = 2'd2,
        SEL_TCTL = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-CLK_DIV prescaler: counts 0..CLK_DIV-1 and flags the last count as
// a one-cycle tick; clear restarts the count from zero at the next edge.
module timer_prescaler #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_count;

    assign tick = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PW'(1);
        end
    end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped timer with counter, limit and write-zero-to-clear status register.
// Define TIMER_IRQ_EN to add the interrupt-enable bit (TCTL[4]) and the irq output.
module timer_device
    import timer_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter int               CLK_DIV   = 100000,
    parameter logic [DBITS-1:0] ADDR_TCNT = DBITS'(DEF_ADDR_TCNT),
    parameter logic [DBITS-1:0] ADDR_TLIM = DBITS'(DEF_ADDR_TLIM),
    parameter logic [DBITS-1:0] ADDR_TCTL = DBITS'(DEF_ADDR_TCTL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrData,
    input  logic             wrEn,
    output logic [DBITS-1:0] rdData,
    output logic             hit
`ifdef TIMER_IRQ_EN
    ,
    output logic             irq
`endif
);

    reg_sel_e         w_sel;
    logic             w_tick;
    logic             w_wr_tcnt;
    logic             w_wr_tlim;
    logic             w_wr_tctl;
    logic             w_wrap;
    logic             w_clr_ready;
    logic             w_clr_ovr;
    logic             w_set_ovr;
    logic             w_ie;
    logic [DBITS-1:0] r_tcnt;
    logic [DBITS-1:0] r_tlim;
    logic             r_ready;
    logic             r_ovr;

    always_comb begin
        w_sel = SEL_NONE;
        if (addr == ADDR_TCNT)      w_sel = SEL_TCNT;
        else if (addr == ADDR_TLIM) w_sel = SEL_TLIM;
        else if (addr == ADDR_TCTL) w_sel = SEL_TCTL;
    end

    assign hit       = (w_sel != SEL_NONE);
    assign w_wr_tcnt = wrEn && (w_sel == SEL_TCNT);
    assign w_wr_tlim = wrEn && (w_sel == SEL_TLIM);
    assign w_wr_tctl = wrEn && (w_sel == SEL_TCTL);

    timer_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_wr_tcnt),
        .tick  (w_tick)
    );

    // A counter store swallows the coinciding tick, including any wrap it would cause.
    assign w_wrap = w_tick && !w_wr_tcnt && (r_tlim != '0) &&
                    (r_tcnt >= r_tlim - DBITS'(1));

    assign w_clr_ready = w_wr_tctl && !wrData[TCTL_READY];
    assign w_clr_ovr   = w_wr_tctl && !wrData[TCTL_OVERRUN];
    // Software acknowledging ready in the wrap cycle has not missed this event.
    assign w_set_ovr   = w_wrap && r_ready && !w_clr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tcnt  <= '0;
            r_tlim  <= '0;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr_tcnt)   r_tcnt <= wrData;
            else if (w_wrap) r_tcnt <= '0;
            else if (w_tick) r_tcnt <= r_tcnt + DBITS'(1);

            if (w_wr_tlim) r_tlim <= wrData;

            r_ready <= (r_ready && !w_clr_ready) || w_wrap;
            r_ovr   <= (r_ovr && !w_clr_ovr) || w_set_ovr;
        end
    end

`ifdef TIMER_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_tctl) r_ie <= wrData[TCTL_IE];
            r_irq <= r_ready && r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
`endif

    always_comb begin
        rdData = '0;
        case (w_sel)
            SEL_TCNT: rdData = r_tcnt;
            SEL_TLIM: rdData = r_tlim;
            SEL_TCTL: begin
                rdData[TCTL_READY]   = r_ready;
                rdData[TCTL_OVERRUN] = r_ovr;
                rdData[TCTL_IE]      = w_ie;
            end
            default: rdData = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device at CLK_DIV=4: reset table, directed
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_timer_device;

    localparam int          CLK_DIV = 4;
    localparam logic [31:0] A_TCNT  = 32'hF000_0020;
    localparam logic [31:0] A_TLIM  = 32'hF000_0024;
    localparam logic [31:0] A_TCTL  = 32'hF000_0028;
    localparam logic [31:0] A_MISS  = 32'hF000_0030;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic        wrEn;
    logic [31:0] rdData;
    logic        hit;
`ifdef TIMER_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int          m_pre   = 0;
    logic [31:0] m_tcnt  = '0;
    logic [31:0] m_tlim  = '0;
    bit          m_ready = 0;
    bit          m_ovr   = 0;
    bit          m_ie    = 0;
    bit          m_irq   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;
    vec_t tbl[5];

    timer_device #(.DBITS(32), .CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wrData (wrData),
        .wrEn   (wrEn),
        .rdData (rdData),
        .hit    (hit)
`ifdef TIMER_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
        addr   = a;
        wrEn   = we;
        wrData = d;
    endtask

    // Applies the timer rules to the model using the inputs present before the edge.
    task automatic model_edge();
        bit tick, st_cnt, st_lim, st_ctl, wrap, ack_ready;
        if (!reset) begin
            m_pre = 0; m_tcnt = '0; m_tlim = '0;
            m_ready = 0; m_ovr = 0; m_ie = 0; m_irq = 0;
            return;
        end
        tick      = (m_pre == CLK_DIV - 1);
        st_cnt    = wrEn && (addr == A_TCNT);
        st_lim    = wrEn && (addr == A_TLIM);
        st_ctl    = wrEn && (addr == A_TCTL);
        wrap      = tick && !st_cnt && (m_tlim != 0) && ({32'd0, m_tcnt} + 64'd1 >= {32'd0, m_tlim});
        ack_ready = st_ctl && (wrData[0] == 1'b0);
`ifdef TIMER_IRQ_EN
        m_irq = m_ready && m_ie;
        if (st_ctl) m_ie = wrData[4];
`endif
        if (st_ctl && wrData[2] == 1'b0) m_ovr = 0;
        if (wrap && m_ready && !ack_ready) m_ovr = 1;
        if (ack_ready) m_ready = 0;
        if (wrap) m_ready = 1;
        if (st_cnt)    m_tcnt = wrData;
        else if (wrap) m_tcnt = '0;
        else if (tick) m_tcnt = m_tcnt + 32'd1;
        if (st_lim) m_tlim = wrData;
        m_pre = st_cnt ? 0 : (m_pre + 1) % CLK_DIV;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == A_TCNT) return m_tcnt;
        if (a == A_TLIM) return m_tlim;
        if (a == A_TCTL) return {27'd0, m_ie, 1'b0, m_ovr, 1'b0, m_ready};
        return 32'd0;
    endfunction

    task automatic tick_clk();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        wrEn = 1'b0;
        #1;
        chk(name, rdData, exp);
    endtask

    task automatic idle(input int n);
        drive(A_MISS, 1'b0, 32'd0);
        for (int k = 0; k < n; k++) tick_clk();
    endtask

    initial begin
        logic [31:0] a, d;
        int sel;

        tbl[0] = '{A_TCTL, 32'd0, 1'b1};
        tbl[1] = '{A_TCNT, 32'd0, 1'b1};
        tbl[2] = '{A_TLIM, 32'd0, 1'b1};
        tbl[3] = '{A_MISS, 32'd0, 1'b0};
        tbl[4] = '{32'hF000_001C, 32'd0, 1'b0};

        // reset held over a concurrent counter store
        reset = 1'b0;
        drive(A_TCNT, 1'b1, 32'd55);
        #1;
        tick_clk();
        tick_clk();
        reset = 1'b1;
        wrEn  = 1'b0;

        for (int i = 0; i < 5; i++) begin
            addr = tbl[i].addr;
            #1;
            chk("reset_rd", rdData, tbl[i].exp_rd);
            chk("reset_hit", {31'd0, hit}, {31'd0, tbl[i].exp_hit});
        end
`ifdef TIMER_IRQ_EN
        chk("reset_irq", {31'd0, irq}, 32'd0);
`endif

        // TLIM=3: count 0,1,2 then wrap to 0 every 4 clocks
        drive(A_TLIM, 1'b1, 32'd3);
        tick_clk();
        rd("tcnt_seq", A_TCNT, 32'd0);
        for (int e = 2; e <= 12; e++) begin
            tick_clk();
            rd("tcnt_seq", A_TCNT, (e < 4) ? 32'd0 : (e < 8) ? 32'd1 : (e < 12) ? 32'd2 : 32'd0);
            if (e == 11) rd("tctl_before_wrap", A_TCTL, 32'd0);
            if (e == 12) rd("tctl_first_wrap", A_TCTL, 32'd1);
        end

        // second wrap with ready still set -> overrun
        idle(12);
        rd("tctl_overrun", A_TCTL, 32'd5);
        drive(A_TCTL, 1'b1, 32'd0);
        tick_clk();
        rd("tctl_cleared", A_TCTL, 32'd0);

        // counter store in the tick cycle beats the tick and restarts the prescaler
        drive(A_TLIM, 1'b1, 32'd0);
        tick_clk();
        idle(1);
        drive(A_TCNT, 1'b1, 32'd100);
        tick_clk();
        rd("tcnt_loaded", A_TCNT, 32'd100);
        idle(3);
        rd("tcnt_hold", A_TCNT, 32'd100);
        idle(1);
        rd("tcnt_incr", A_TCNT, 32'd101);

        // acknowledge ready in the same cycle as a wrap
        drive(A_TLIM, 1'b1, 32'd2);
        tick_clk();
        idle(3);
        rd("tctl_wrap_lim2", A_TCTL, 32'd1);
        rd("tcnt_wrap_lim2", A_TCNT, 32'd0);
        idle(7);
        drive(A_TCTL, 1'b1, 32'd0);
        tick_clk();
        rd("tctl_ack_in_wrap", A_TCTL, 32'd1);
        rd("tcnt_ack_in_wrap", A_TCNT, 32'd0);

        drive(A_TCTL, 1'b1, 32'd16);
        tick_clk();
`ifdef TIMER_IRQ_EN
        rd("tctl_ie_set", A_TCTL, 32'd16);
        idle(7);
        rd("tctl_ie_ready", A_TCTL, 32'd17);
        chk("irq_not_yet", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        drive(A_TCTL, 1'b1, 32'd16);
        tick_clk();
        idle(1);
        chk("irq_fall", {31'd0, irq}, 32'd0);
        rd("tctl_ie_kept", A_TCTL, 32'd16);
`else
        rd("tctl_ie_absent", A_TCTL, 32'd0);
`endif

        // randomized traffic against the model
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        for (int c = 0; c < 500; c++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: a = A_TCNT;
                1: a = A_TLIM;
                2: a = A_TCTL;
                3: a = A_MISS;
                default: a = $urandom;
            endcase
            if (sel == 0) d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 6));
            else if (sel == 1) d = 32'($urandom_range(0, 5));
            else d = $urandom;
            reset = ($urandom_range(0, 60) != 0);
            drive(a, ($urandom_range(0, 2) == 0), d);
            #1;
            chk("rand_rd", rdData, model_read(a));
            chk("rand_hit", {31'd0, hit},
                {31'd0, (a == A_TCNT) || (a == A_TLIM) || (a == A_TCTL)});
`ifdef TIMER_IRQ_EN
            chk("rand_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
            tick_clk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_device.md
TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 SHALL have parameter DBITS, default 32, data and address width.
REQ-002 SHALL have parameter CLK_DIV, default 100000, clk cycles per timer tick; legal range >= 2.
REQ-003 SHALL have parameter ADDR_TCNT, default 32'hF0000020, counter register address.
REQ-004 SHALL have parameter ADDR_TLIM, default 32'hF0000024, limit register address.
REQ-005 SHALL have parameter ADDR_TCTL, default 32'hF0000028, control/status register address.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port addr  input  DBITS  bus address from the processor (base plus immediate).
REQ-009 SHALL have port wrData  input  DBITS  store data.
REQ-010 SHALL have port wrEn  input  1  store strobe, one cycle per store.
REQ-011 SHALL have port rdData  output  DBITS  load data, combinational.
REQ-012 SHALL have port hit  output  1  high when addr equals any of the three register addresses.
REQ-013 SHALL have port irq  output  1  interrupt request; present only under TIMER_IRQ_EN.

Function
REQ-014 Prescaler SHALL count 0..CLK_DIV-1 and assert a one-cycle tick when it equals CLK_DIV-1, then wrap to 0.
REQ-015 On tick with TLIM != 0 and TCNT >= TLIM-1, TCNT SHALL go to 0 and a wrap event SHALL occur.
REQ-016 On tick otherwise, TCNT SHALL increment modulo 2^DBITS; TLIM == 0 means free-running, no wrap events.
REQ-017 Wrap event SHALL set TCTL[0] (ready); if TCTL[0] is already 1, it SHALL also set TCTL[2] (overrun).
REQ-018 rdData SHALL equal the addressed register in the same cycle (zero-latency); 0 when hit is low.
REQ-019 Unused TCTL bits SHALL read 0.
REQ-020 Store to ADDR_TCNT SHALL load TCNT and clear the prescaler at the next edge; it beats a simultaneous tick.
REQ-021 Store to ADDR_TLIM SHALL load TLIM without disturbing TCNT or the prescaler.
REQ-022 Store to ADDR_TCTL SHALL clear bit 0 and/or bit 2 where wrData has 0; a 1 SHALL leave that bit unchanged (write-zero-to-clear).
REQ-023 A wrap event coinciding with a TCTL store clearing bit 0 SHALL leave bit 0 at 1 and SHALL NOT set bit 2.
REQ-024 wrEn with no address hit SHALL change no state.

Reset
REQ-025 With reset low at an edge, TCNT, TLIM, TCTL and the prescaler SHALL become 0; irq SHALL be 0.
REQ-026 Reset SHALL override any concurrent store or tick; counting SHALL resume from prescaler 0 on the first edge after release.

Configuration
REQ-027 Macro TIMER_IRQ_EN defined: TCTL[4] SHALL be a read/write interrupt-enable bit, and irq SHALL equal TCTL[0] AND TCTL[4], registered output.
REQ-028 TIMER_IRQ_EN undefined: no irq port, TCTL[4] SHALL read 0 and ignore writes.

Structure
REQ-029 Package timer_pkg SHALL hold the default register addresses and TCTL bit positions (READY=0, OVERRUN=2, IE=4).
REQ-030 The prescaler SHALL be sub-module timer_prescaler (clk, reset, clear, tick).

Verification (CLK_DIV=4)
REQ-031 Reset low 2 cycles, release, read TCTL/TCNT/TLIM -> all 0, hit=1 for each address, hit=0 at 32'hF0000030.
REQ-032 TLIM=3, run 12 cycles -> TCNT sequence 0,1,2,0 at ticks; TCTL reads 1 after first wrap.
REQ-033 Leave ready set through a second wrap -> TCTL=5; store 0 to TCTL -> TCTL=0.
REQ-034 Store TCNT=100 in the tick cycle -> TCNT=100, next increment 4 cycles later to 101.
REQ-035 Store TCTL=0 in the wrap cycle -> TCTL=1, overrun stays 0.
REQ-036 TIMER_IRQ_EN defined, TCTL=16, TLIM=2 -> irq rises one cycle after wrap; store 16 to TCTL -> irq falls.
